// File: rtl/gate_circuit_bist.sv
// gate_circuit_bist: built-in self-test driver for the three-input gate
// circuit F = (~X & Y) | (Y & Z). It sweeps all eight {X,Y,Z} vectors,
// holds each for HOLD_CYCLES cycles, samples f on the last cycle of each
// window and compares it against EXPECTED.
//
// Optional feature macro: GATE_BIST_STOP_ON_FAIL_EN
//   defined   -> the first mismatch ends the sweep immediately
//   undefined -> all eight vectors are always swept
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle sweep request (ignored while busy)
//   f          in   circuit-under-test output
//   x, y, z    out  registered drive to the circuit under test
//   busy       out  sweep in progress
//   done       out  sweep finished, results valid until next start
//   pass       out  valid with done; 1 when err_count == 0
//   err_count  out  number of mismatching vectors (0..8)
//   fail_mask  out  bit i set when vector i mismatched
module gate_circuit_bist #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXPECTED    = 8'h8C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] ERR_MAX   = 4'd8;
    localparam logic [2:0] VEC_LAST  = 3'd7;

    logic [1:0] state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] err_q, err_d;
    logic [7:0] mask_q, mask_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] xyz_q, xyz_d;
    logic       mismatch;

    // Next-state, result update and registered-output precompute
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        hold_d   = hold_q;
        err_d    = err_q;
        mask_d   = mask_q;
        mismatch = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d   = 4'd0;
                    mask_d  = 8'd0;
                    vec_d   = 3'd0;
                    hold_d  = 8'd0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                hold_d = hold_q + 8'd1;
                if (hold_q == HOLD_LAST) begin
                    mismatch = (f != EXPECTED[vec_q]);
                    if (mismatch) begin
                        if (err_q < ERR_MAX) begin
                            err_d = err_q + 4'd1;
                        end
                        mask_d[vec_q] = 1'b1;
                    end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                    if (mismatch || vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d  = vec_q + 3'd1;
                        hold_d = 8'd0;
                    end
`else
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d  = vec_q + 3'd1;
                        hold_d = 8'd0;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register with it
        busy_d = (state_d == S_APPLY);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 4'd0);
        xyz_d  = busy_d ? vec_d : 3'd0;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 3'd0;
            hold_q  <= 8'd0;
            err_q   <= 4'd0;
            mask_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            xyz_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            xyz_q   <= xyz_d;
        end
    end

    assign {x, y, z}  = xyz_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_mask  = mask_q;

endmodule

// File: tb/tb_gate_circuit_bist.sv
// Directed testbench for gate_circuit_bist: a HOLD_CYCLES=4 instance with a
// selectable circuit model on f, and a HOLD_CYCLES=1 instance driven by the
// correct circuit.
module tb_gate_circuit_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic       f, f1;
    logic       x, y, z, busy, done, pass;
    logic       x1, y1, z1, busy1, done1, pass1;
    logic [3:0] err_count, err_count1;
    logic [7:0] fail_mask, fail_mask1;
    int         mode;  // 0: correct circuit, 1: f tied 0, 2: f tied 1
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (mode == 0)      f = (~x & y) | (y & z);
        else if (mode == 1) f = 1'b0;
        else                f = 1'b1;
    end

    assign f1 = (~x1 & y1) | (y1 & z1);

    gate_circuit_bist #(.HOLD_CYCLES(4), .EXPECTED(8'h8C)) dut (
        .clk(clk), .rst(rst), .start(start), .f(f),
        .x(x), .y(y), .z(z), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask)
    );

    gate_circuit_bist #(.HOLD_CYCLES(1), .EXPECTED(8'h8C)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .f(f1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_mask(fail_mask1)
    );

    task automatic check_idle(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || {x, y, z} !== 3'b000 ||
            err_count !== 4'd0 || fail_mask !== 8'h00) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b pass=%b xyz=%b err=%0d mask=%h, want all zero",
                     tag, busy, done, pass, {x, y, z}, err_count, fail_mask);
        end
    endtask

    // Pulses start, checks every cycle of the sweep and the final verdict.
    // full_mask is the mismatch set for a complete sweep.
    task automatic run_sweep(input string tag, input logic [7:0] full_mask, input int restart_at);
        int         exp_err;
        int         lat;
        logic [7:0] exp_mask;
        logic [2:0] ev;
        exp_err  = $countones(full_mask);
        exp_mask = full_mask;
        lat      = 32;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        if (full_mask != 8'h00) begin
            int first;
            first = 0;
            for (int i = 7; i >= 0; i--) if (full_mask[i]) first = i;
            exp_err  = 1;
            exp_mask = 8'd1 << first;
            lat      = (first + 1) * 4;
        end
`endif
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 0; n < lat; n++) begin
            ev = 3'(n / 4);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || {x, y, z} !== ev) begin
                errors++;
                $display("FAIL %s cyc %0d: busy=%b done=%b xyz=%b, want busy=1 done=0 xyz=%b",
                         tag, n, busy, done, {x, y, z}, ev);
            end
            start = (n == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || {x, y, z} !== 3'b000 ||
            err_count !== 4'(exp_err) || fail_mask !== exp_mask ||
            pass !== (exp_err == 0)) begin
            errors++;
            $display("FAIL %s end: busy=%b done=%b xyz=%b err=%0d mask=%h pass=%b, want 0 1 000 %0d %h %b",
                     tag, busy, done, {x, y, z}, err_count, fail_mask, pass,
                     exp_err, exp_mask, (exp_err == 0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");
    endtask

    task automatic test_correct();
        mode = 0;
        run_sweep("correct", 8'h00, -1);
    endtask

    task automatic test_tie0();
        mode = 1;
        run_sweep("tie0", 8'h8C, -1);
    endtask

    task automatic test_tie1();
        mode = 2;
        run_sweep("tie1", 8'h73, -1);
    endtask

    task automatic test_restart_busy();
        mode = 0;
        run_sweep("restart_busy", 8'h00, 10);
    endtask

    // Sweep with recorded failures, then start from DONE clears them
    task automatic test_start_in_done();
        mode = 1;
        run_sweep("pre_done", 8'h8C, -1);
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_count !== 4'd0 ||
            fail_mask !== 8'h00 || pass !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: done=%b busy=%b err=%0d mask=%h pass=%b, want 0 1 0 00 0",
                     done, busy, err_count, fail_mask, pass);
        end
        repeat (32) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 4'd0 || fail_mask !== 8'h00) begin
            errors++;
            $display("FAIL start_in_done end: done=%b pass=%b err=%0d mask=%h, want 1 1 0 00",
                     done, pass, err_count, fail_mask);
        end
    endtask

    task automatic test_reset_mid();
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (13) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {x, y, z} !== 3'b011) begin
            errors++;
            $display("FAIL pre_rst: busy=%b xyz=%b, want 1 011", busy, {x, y, z});
        end
        #1 rst = 1'b1;
        #1 check_idle("mid_reset");
        @(negedge clk) rst = 1'b0;
        check_idle("after_mid_reset");
        run_sweep("post_rst", 8'h00, -1);
    endtask

    task automatic test_hold1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || {x1, y1, z1} !== 3'(n)) begin
                errors++;
                $display("FAIL hold1 cyc %0d: busy=%b done=%b xyz=%b, want 1 0 %b",
                         n, busy1, done1, {x1, y1, z1}, 3'(n));
            end
            @(negedge clk);
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== 1'b1 ||
            err_count1 !== 4'd0 || fail_mask1 !== 8'h00) begin
            errors++;
            $display("FAIL hold1 end: done=%b busy=%b pass=%b err=%0d mask=%h, want 1 0 1 0 00",
                     done1, busy1, pass1, err_count1, fail_mask1);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_tie0();
        test_tie1();
        test_restart_busy();
        test_start_in_done();
        test_reset_mid();
        test_hold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
